ball_engine: RTL

Parametrised ball-motion and rally engine for the VGA pong game. Replaces the fixed 640x480, single-speed ball with configurable playfield geometry, step size, lives, and a serve/play/game-over state machine. It also adds hit/miss event pulses for the sound and scoreboard logic. Sits between the paddle controller (`p_y`) and the pixel generator (`ball_x`, `ball_y`).

---
 rtl/pong_pkg.sv | 32 +++
 rtl/tick_gen.sv | 28 ++
 rtl/ball_engine.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared pong types and default playfield geometry for the ball engine and its peers.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } state_t;

    // Direction vector: bit1 set = moving right, bit0 set = moving down.
    typedef logic [1:0] dir_t;
    localparam int   DIR_RIGHT = 1;
    localparam int   DIR_DOWN  = 0;
    localparam dir_t DIR_SERVE = 2'b11;

    localparam int POS_W = 10;
    localparam int EXT_W = 11;

    localparam int DEF_H_RES          = 640;
    localparam int DEF_V_RES          = 480;
    localparam int DEF_BALL_W         = 8;
    localparam int DEF_LEFT_WALL      = 35;
    localparam int DEF_PADDLE_X       = 600;
    localparam int DEF_PADDLE_H       = 72;
    localparam int DEF_TICK_DIV       = 500000;
    localparam int DEF_STEP           = 1;
    localparam int DEF_MAX_STEP       = 4;
    localparam int DEF_HITS_PER_LEVEL = 4;
    localparam int DEF_LIVES          = 3;
    localparam int DEF_SCORE_W        = 16;

endpackage

// File: rtl/tick_gen.sv
// Free-running motion tick: a one-cycle strobe every TICK_DIV clocks, shared with the paddle controller.
module tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/ball_engine.sv
// Pong ball motion and rally engine: serve/play/game-over FSM, wall and paddle bounces, lives and score.
// Optional BALL_SPEEDUP_EN raises the per-tick step every HITS_PER_LEVEL paddle hits.
module ball_engine
    import pong_pkg::*;
#(
    parameter int H_RES          = DEF_H_RES,
    parameter int V_RES          = DEF_V_RES,
    parameter int BALL_W         = DEF_BALL_W,
    parameter int LEFT_WALL      = DEF_LEFT_WALL,
    parameter int PADDLE_X       = DEF_PADDLE_X,
    parameter int PADDLE_H       = DEF_PADDLE_H,
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int STEP           = DEF_STEP,
    parameter int MAX_STEP       = DEF_MAX_STEP,
    parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
    parameter int LIVES          = DEF_LIVES,
    parameter int SCORE_W        = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [POS_W-1:0]   p_y,
    input  logic               serve,
    input  logic               pause,
    input  logic               konami,
    output logic [POS_W-1:0]   ball_x,
    output logic [POS_W-1:0]   ball_y,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic [1:0]         state,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    localparam logic [EXT_W-1:0] C_BALL_W   = EXT_W'(BALL_W);
    localparam logic [EXT_W-1:0] C_LEFT     = EXT_W'(LEFT_WALL);
    localparam logic [EXT_W-1:0] C_RIGHT    = EXT_W'(H_RES - 1);
    localparam logic [EXT_W-1:0] C_BOTTOM   = EXT_W'(V_RES - 1);
    localparam logic [EXT_W-1:0] C_PADDLE_X = EXT_W'(PADDLE_X);
    localparam logic [EXT_W-1:0] C_PADDLE_H = EXT_W'(PADDLE_H);
    localparam logic [POS_W-1:0] C_SERVE_X  = POS_W'(LEFT_WALL);
    localparam logic [POS_W-1:0] C_SERVE_Y  = POS_W'(V_RES / 2);
    localparam logic [POS_W-1:0] C_Y_FLOOR  = POS_W'(V_RES - 1 - BALL_W);
    localparam logic [POS_W-1:0] C_X_HIT    = POS_W'(PADDLE_X - BALL_W);

    state_t             r_state;
    dir_t               r_dir;
    logic [POS_W-1:0]   r_x;
    logic [POS_W-1:0]   r_y;
    logic [SCORE_W-1:0] r_score;
    logic [2:0]         r_lives;
    logic               r_hit_pulse;
    logic               r_miss_pulse;

    logic             w_tick;
    logic             w_move;
    logic [EXT_W-1:0] w_step;
    logic [EXT_W-1:0] w_x;
    logic [EXT_W-1:0] w_y;
    logic [EXT_W-1:0] w_py;
    logic             w_right;
    logic             w_down;
    logic             w_top;
    logic             w_bottom;
    logic             w_left;
    logic             w_hit;
    logic             w_miss;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_move  = (r_state == PLAY) && w_tick && !pause;
    assign w_x     = {1'b0, r_x};
    assign w_y     = {1'b0, r_y};
    assign w_py    = {1'b0, p_y};
    assign w_right = r_dir[DIR_RIGHT];
    assign w_down  = r_dir[DIR_DOWN];

    // Each axis is judged independently so a corner flips both directions in one tick.
    assign w_top    = !w_down && (w_y <= w_step);
    assign w_bottom = w_down && (w_y + C_BALL_W + w_step >= C_BOTTOM);
    assign w_left   = !w_right && (w_x <= C_LEFT + w_step);
    assign w_hit    = w_right
                    && (w_x + C_BALL_W <= C_PADDLE_X)
                    && (w_x + C_BALL_W + w_step >= C_PADDLE_X)
                    && (w_y + C_BALL_W > w_py)
                    && (w_y < w_py + C_PADDLE_H);
    assign w_miss   = w_right && !w_hit && (w_x + C_BALL_W + w_step >= C_RIGHT);

`ifdef BALL_SPEEDUP_EN
    localparam int HIT_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    logic [EXT_W-1:0] r_step;
    logic [HIT_W-1:0] r_hits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step <= EXT_W'(STEP);
            r_hits <= '0;
        end else if (w_move && w_miss) begin
            r_step <= EXT_W'(STEP);
            r_hits <= '0;
        end else if (w_move && w_hit) begin
            if (r_hits == HIT_W'(HITS_PER_LEVEL - 1)) begin
                r_hits <= '0;
                if (r_step < EXT_W'(MAX_STEP)) begin
                    r_step <= r_step + 1'b1;
                end
            end else begin
                r_hits <= r_hits + 1'b1;
            end
        end
    end

    assign w_step = r_step;
`else
    logic w_unused_cfg;

    assign w_step       = EXT_W'(STEP);
    assign w_unused_cfg = ^{HITS_PER_LEVEL, MAX_STEP};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= SERVE;
            r_dir        <= DIR_SERVE;
            r_x          <= C_SERVE_X;
            r_y          <= C_SERVE_Y;
            r_score      <= '0;
            r_lives      <= 3'(LIVES);
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
        end else begin
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            unique case (r_state)
                SERVE: begin
                    if (serve) begin
                        r_state <= PLAY;
                    end
                end
                PLAY: begin
                    if (w_move && w_miss) begin
                        r_miss_pulse <= 1'b1;
                        r_lives      <= r_lives - 3'd1;
                        r_state      <= (r_lives == 3'd1) ? OVER : SERVE;
                        r_dir        <= DIR_SERVE;
                        r_x          <= C_SERVE_X;
                        r_y          <= C_SERVE_Y;
                    end else if (w_move) begin
                        if (w_top) begin
                            r_y               <= '0;
                            r_dir[DIR_DOWN]   <= 1'b1;
                        end else if (w_bottom) begin
                            r_y               <= C_Y_FLOOR;
                            r_dir[DIR_DOWN]   <= 1'b0;
                        end else if (w_down) begin
                            r_y <= POS_W'(w_y + w_step);
                        end else begin
                            r_y <= POS_W'(w_y - w_step);
                        end

                        if (w_hit) begin
                            r_x              <= C_X_HIT;
                            r_dir[DIR_RIGHT] <= 1'b0;
                            r_hit_pulse      <= 1'b1;
                            if (r_score != '1) begin
                                r_score <= r_score + 1'b1;
                            end
                        end else if (w_left) begin
                            r_x              <= C_SERVE_X;
                            r_dir[DIR_RIGHT] <= 1'b1;
                        end else if (w_right) begin
                            r_x <= POS_W'(w_x + w_step);
                        end else begin
                            r_x <= POS_W'(w_x - w_step);
                        end
                    end
                end
                OVER: begin
                    if (serve) begin
                        r_state <= SERVE;
                        r_score <= '0;
                        r_lives <= 3'(LIVES);
                    end
                end
                default: r_state <= SERVE;
            endcase
            if (konami) begin
                r_score <= '1;
            end
        end
    end

    assign ball_x     = r_x;
    assign ball_y     = r_y;
    assign score      = r_score;
    assign lives      = r_lives;
    assign state      = r_state;
    assign hit_pulse  = r_hit_pulse;
    assign miss_pulse = r_miss_pulse;

endmodule
